// File: rtl/usb_buf_pkg.sv
// usb_buf_pkg: shared sizes, FSM state type and the
// AHB access-size to byte-count helper for the USB buffer arbiter.
package usb_buf_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int PTR_W     = 6;
  localparam int OCC_W     = 7;

  typedef enum logic [1:0] {
    IDLE,
    AHB_XFER,
    USB_XFER
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/usb_buffer_arbiter_if.sv
// usb_buffer_arbiter_if: AHB strobes/data, USB RX/TX handshakes and
// buffer status. master = AHB slave + USB engines, slave = arbiter.
interface usb_buffer_arbiter_if;
  import usb_buf_pkg::*;

  logic             storeTxData;
  logic             getRxData;
  logic [1:0]       dataSize;
  logic [31:0]      txData;
  logic [31:0]      rxData;
  logic             ahbDone;
  logic             ahbErr;
  logic             rxStore;
  logic [7:0]       rxByte;
  logic             rxAck;
  logic             rxOverflow;
  logic             txGet;
  logic [7:0]       txByte;
  logic             txAck;
  logic             txUnderflow;
  logic [OCC_W-1:0] bufferOccupancy;
  logic             bufferEmpty;
  logic             bufferFull;

  modport master (
    output storeTxData, getRxData, dataSize, txData,
    output rxStore, rxByte, txGet,
    input  rxData, ahbDone, ahbErr,
    input  rxAck, rxOverflow, txByte, txAck, txUnderflow,
    input  bufferOccupancy, bufferEmpty, bufferFull
  );

  modport slave (
    input  storeTxData, getRxData, dataSize, txData,
    input  rxStore, rxByte, txGet,
    output rxData, ahbDone, ahbErr,
    output rxAck, rxOverflow, txByte, txAck, txUnderflow,
    output bufferOccupancy, bufferEmpty, bufferFull
  );

endinterface

// File: rtl/usb_byte_store.sv
// usb_byte_store: 64x8 endpoint buffer array.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module usb_byte_store
  import usb_buf_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter: shares the byte port of the endpoint buffer
// between AHB bursts and USB byte requests. Ports: clk, rst, flush, bus.
module usb_buffer_arbiter
  import usb_buf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  usb_buffer_arbiter_if.slave bus
);

  state_t state, state_n;

  logic             last_ahb;
  logic             pend, pend_wr;
  logic [2:0]       pend_n;
  logic [31:0]      pend_data;
  logic             cur_wr;
  logic [2:0]       cur_n;
  logic [31:0]      cur_data;
  logic [1:0]       idx;
  logic             usb_rx;
  logic [PTR_W-1:0] wptr, rptr;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic             empty, full;
  logic [31:0]      rd_acc, rd_word, rx_data_q;
  logic [7:0]       tx_byte_q, rdata, mem_wd;
  logic             done_q, err_q;
  logic             rx_ack_q, rx_ovf_q;
  logic             tx_ack_q, tx_unf_q;

  logic             new_pulse, ahb_valid, ahb_ok;
  logic             rx_req, tx_req, usb_valid;
  logic             req_wr;
  logic [2:0]       req_n;
  logic [31:0]      req_data;
  logic             grant_ahb, grant_usb;
  logic             mem_we, do_rd, last_byte;

  // A second pulse while an op is pending or bursting is dropped.
  assign new_pulse = (bus.storeTxData | bus.getRxData)
                   & ~pend & (state != AHB_XFER);
  assign ahb_valid = pend | new_pulse;
  assign req_wr    = pend ? pend_wr   : bus.storeTxData;
  assign req_n     = pend ? pend_n    : size_bytes(bus.dataSize);
  assign req_data  = pend ? pend_data : bus.txData;
  assign ahb_ok    = req_wr
                   ? (7'(BUF_DEPTH) - occ) >= {4'b0, req_n}
                   : occ >= {4'b0, req_n};

  // Level requests are still high in the ack cycle; mask them there.
  assign rx_req    = bus.rxStore & ~rx_ack_q;
  assign tx_req    = bus.txGet & ~tx_ack_q;
  assign usb_valid = rx_req | tx_req;

  assign occ_nxt = occ + {6'b0, mem_we} - {6'b0, do_rd};
  assign rd_word = rd_acc | ({24'b0, rdata} << {idx, 3'b000});

  usb_byte_store u_store (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (mem_wd),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_ahb = 1'b0;
    grant_usb = 1'b0;
    mem_we    = 1'b0;
    mem_wd    = 8'h00;
    do_rd     = 1'b0;
    last_byte = 1'b0;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // Tie goes to whoever was not granted last.
          grant_ahb = ahb_valid & (~usb_valid | ~last_ahb);
          grant_usb = usb_valid & ~grant_ahb;
          if (grant_ahb && ahb_ok) state_n = AHB_XFER;
          else if (grant_usb)      state_n = USB_XFER;
        end
        AHB_XFER: begin
          last_byte = ({1'b0, idx} == cur_n - 3'd1);
          if (cur_wr) begin
            mem_we = 1'b1;
            mem_wd = cur_data[{idx, 3'b000} +: 8];
          end else begin
            do_rd = 1'b1;
          end
          if (last_byte) state_n = IDLE;
        end
        USB_XFER: begin
          state_n = IDLE;
          if (usb_rx) begin
            mem_we = ~full;
            mem_wd = bus.rxByte;
          end else begin
            do_rd = ~empty;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ahb  <= 1'b1;
      pend      <= 1'b0;
      pend_wr   <= 1'b0;
      pend_n    <= 3'd0;
      pend_data <= 32'h0;
      cur_wr    <= 1'b0;
      cur_n     <= 3'd0;
      cur_data  <= 32'h0;
      idx       <= 2'd0;
      usb_rx    <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      occ       <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      rd_acc    <= 32'h0;
      rx_data_q <= 32'h0;
      tx_byte_q <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_ack_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_ack_q  <= 1'b0;
      tx_unf_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rx_ack_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      tx_ack_q <= 1'b0;
      tx_unf_q <= 1'b0;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        occ   <= '0;
        empty <= 1'b1;
        full  <= 1'b0;
        pend  <= 1'b0;
        if (state == AHB_XFER) err_q <= 1'b1;
      end else begin
        if (new_pulse) begin
          pend      <= 1'b1;
          pend_wr   <= bus.storeTxData;
          pend_n    <= size_bytes(bus.dataSize);
          pend_data <= bus.txData;
        end
        if (grant_ahb | grant_usb) last_ahb <= grant_ahb;
        if (grant_ahb) begin
          pend <= 1'b0;
          if (ahb_ok) begin
            cur_wr   <= req_wr;
            cur_n    <= req_n;
            cur_data <= req_data;
            idx      <= 2'd0;
            rd_acc   <= 32'h0;
          end else begin
            err_q <= 1'b1;
          end
        end
        if (grant_usb) usb_rx <= rx_req;
        if (mem_we) wptr <= wptr + 6'd1;
        if (do_rd)  rptr <= rptr + 6'd1;
        occ   <= occ_nxt;
        empty <= (occ_nxt == '0);
        full  <= (occ_nxt == 7'(BUF_DEPTH));
        if (state == AHB_XFER) begin
          idx <= idx + 2'd1;
          if (!cur_wr) rd_acc <= rd_word;
          if (last_byte) begin
            done_q <= 1'b1;
            if (!cur_wr) rx_data_q <= rd_word;
          end
        end
        if (state == USB_XFER) begin
          if (usb_rx) begin
            rx_ack_q <= 1'b1;
            rx_ovf_q <= full;
          end else begin
            tx_ack_q  <= 1'b1;
            tx_unf_q  <= empty;
            tx_byte_q <= empty ? 8'h00 : rdata;
          end
        end
      end
    end
  end

  assign bus.rxData          = rx_data_q;
  assign bus.ahbDone         = done_q;
  assign bus.ahbErr          = err_q;
  assign bus.rxAck           = rx_ack_q;
  assign bus.rxOverflow      = rx_ovf_q;
  assign bus.txByte          = tx_byte_q;
  assign bus.txAck           = tx_ack_q;
  assign bus.txUnderflow     = tx_unf_q;
  assign bus.bufferOccupancy = occ;
  assign bus.bufferEmpty     = empty;
  assign bus.bufferFull      = full;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// tb_usb_buffer_arbiter: directed checks of arbitration, bursts,
// full/empty handling, pointer wrap and flush abort.
module tb_usb_buffer_arbiter;

  logic clk, rst, flush;
  int   n_chk, n_fail;

  usb_buffer_arbiter_if bus ();

  usb_buffer_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ahb_op(input logic wr, input logic [1:0] sz,
                        input logic [31:0] d,
                        output int lat, output logic err);
    @(posedge clk); #1;
    if (wr) bus.storeTxData = 1'b1;
    else    bus.getRxData   = 1'b1;
    bus.dataSize = sz;
    bus.txData   = d;
    @(posedge clk); #1;
    bus.storeTxData = 1'b0;
    bus.getRxData   = 1'b0;
    lat = -1;
    err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.ahbDone || bus.ahbErr) begin
        lat = k;
        err = bus.ahbErr;
        break;
      end
    end
  endtask

  task automatic rx_op(input logic [7:0] b,
                       output logic ovf, output int lat);
    @(posedge clk); #1;
    bus.rxStore = 1'b1;
    bus.rxByte  = b;
    lat = -1;
    ovf = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rxAck) begin
        lat = k;
        ovf = bus.rxOverflow;
        break;
      end
    end
    @(posedge clk); #1;
    bus.rxStore = 1'b0;
  endtask

  task automatic tx_op(output logic [7:0] b,
                       output logic unf, output int lat);
    @(posedge clk); #1;
    bus.txGet = 1'b1;
    lat = -1;
    unf = 1'b0;
    b   = 8'hxx;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (bus.txAck) begin
        lat = k;
        unf = bus.txUnderflow;
        b   = bus.txByte;
        break;
      end
    end
    @(posedge clk); #1;
    bus.txGet = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // Both requesters raised in one cycle; records ack cycle offsets.
  task automatic tie(input logic [1:0] sz, input logic [31:0] d,
                     input logic [7:0] b,
                     output int rx_k, output int ahb_k);
    @(posedge clk); #1;
    bus.storeTxData = 1'b1;
    bus.dataSize    = sz;
    bus.txData      = d;
    bus.rxStore     = 1'b1;
    bus.rxByte      = b;
    rx_k  = -1;
    ahb_k = -1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (bus.rxAck)   rx_k  = k;
      if (bus.ahbDone) ahb_k = k;
      @(posedge clk); #1;
      bus.storeTxData = 1'b0;
      if (rx_k >= 0) bus.rxStore = 1'b0;
    end
  endtask

  initial begin
    int         lat, rk, ak, bad;
    logic       err, flag;
    logic [7:0] b;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    bus.storeTxData = 1'b0;
    bus.getRxData   = 1'b0;
    bus.dataSize    = 2'd0;
    bus.txData      = 32'h0;
    bus.rxStore     = 1'b0;
    bus.rxByte      = 8'h0;
    bus.txGet       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_occ",   32'(bus.bufferOccupancy), 0);
    check("rst_empty", 32'(bus.bufferEmpty), 1);
    check("rst_full",  32'(bus.bufferFull), 0);
    check("rst_rxdata", bus.rxData, 0);
    check("rst_txbyte", 32'(bus.txByte), 0);
    check("rst_pulses",
          {26'b0, bus.ahbDone, bus.ahbErr, bus.rxAck,
           bus.txAck, bus.rxOverflow, bus.txUnderflow}, 0);

    tie(2'd2, 32'h44332211, 8'h99, rk, ak);
    check("tie1_rx_k",  rk, 2);
    check("tie1_ahb_k", ak, 7);
    check("tie1_occ", 32'(bus.bufferOccupancy), 5);
    tx_op(b, flag, lat);
    check("tie1_first_byte", 32'(b), 32'h99);
    tie(2'd1, 32'h00005566, 8'h77, rk, ak);
    check("tie2_ahb_k", ak, 3);
    check("tie2_rx_k",  rk, 5);
    check("tie2_occ", 32'(bus.bufferOccupancy), 7);
    do_flush();
    @(negedge clk);
    check("flush_occ",   32'(bus.bufferOccupancy), 0);
    check("flush_empty", 32'(bus.bufferEmpty), 1);

    ahb_op(1'b1, 2'd2, 32'hDDCCBBAA, lat, err);
    check("wr4_lat", lat, 5);
    check("wr4_err", 32'(err), 0);
    check("wr4_occ", 32'(bus.bufferOccupancy), 4);
    ahb_op(1'b0, 2'd2, 32'h0, lat, err);
    check("rd4_lat", lat, 5);
    check("rd4_data", bus.rxData, 32'hDDCCBBAA);
    check("rd4_occ", 32'(bus.bufferOccupancy), 0);
    check("rd4_empty", 32'(bus.bufferEmpty), 1);

    bad = 0;
    for (int i = 0; i < 64; i++) begin
      rx_op(8'(i), flag, lat);
      if (flag !== 1'b0 || lat != 2) bad++;
    end
    check("fill_bad", bad, 0);
    check("fill_full", 32'(bus.bufferFull), 1);
    check("fill_occ", 32'(bus.bufferOccupancy), 64);
    rx_op(8'hEE, flag, lat);
    check("ovf_flag", 32'(flag), 1);
    check("ovf_lat", lat, 2);
    check("ovf_occ", 32'(bus.bufferOccupancy), 64);
    ahb_op(1'b1, 2'd0, 32'h12, lat, err);
    check("full_wr_err", 32'(err), 1);
    check("full_wr_lat", lat, 1);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      tx_op(b, flag, lat);
      if (b !== 8'(i) || flag !== 1'b0) bad++;
    end
    check("drain_bad", bad, 0);
    check("drain_empty", 32'(bus.bufferEmpty), 1);
    tx_op(b, flag, lat);
    check("unf_flag", 32'(flag), 1);
    check("unf_byte", 32'(b), 0);

    do_flush();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      rx_op(8'(i) ^ 8'hA5, flag, lat);
    end
    for (int i = 0; i < 60; i++) begin
      tx_op(b, flag, lat);
      if (b !== (8'(i) ^ 8'hA5)) bad++;
    end
    for (int i = 0; i < 8; i++) begin
      rx_op(8'hC0 + 8'(i), flag, lat);
    end
    check("wrap_occ8", 32'(bus.bufferOccupancy), 8);
    for (int i = 0; i < 8; i++) begin
      tx_op(b, flag, lat);
      if (b !== 8'hC0 + 8'(i) || flag !== 1'b0) bad++;
    end
    check("wrap_bad", bad, 0);
    check("wrap_occ0", 32'(bus.bufferOccupancy), 0);

    rx_op(8'h5A, flag, lat);
    ahb_op(1'b0, 2'd1, 32'h0, lat, err);
    check("short_rd_err", 32'(err), 1);
    check("short_rd_lat", lat, 1);
    check("short_rd_occ", 32'(bus.bufferOccupancy), 1);
    check("short_rd_data", bus.rxData, 32'hDDCCBBAA);
    ahb_op(1'b0, 2'd0, 32'h0, lat, err);
    check("rd1_lat", lat, 2);
    check("rd1_data", bus.rxData, 32'h0000005A);

    @(posedge clk); #1;
    bus.storeTxData = 1'b1;
    bus.dataSize    = 2'd2;
    bus.txData      = 32'h87654321;
    @(posedge clk); #1;
    bus.storeTxData = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("abort_occ_mid", 32'(bus.bufferOccupancy), 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("abort_err", 32'(bus.ahbErr), 1);
    check("abort_occ", 32'(bus.bufferOccupancy), 0);
    check("abort_empty", 32'(bus.bufferEmpty), 1);
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ahbDone) flag = 1'b1;
    end
    check("abort_no_done", 32'(flag), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
